// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 byte transmitter: inhibits the clock, issues a request-to-send,
// shifts out start/data/parity/stop on device falling edges, then checks the device ack.
module ps2_host_transmitter #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int unsigned InhW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned ToW  = ($clog2(TIMEOUT_CYCLES + 1) > 24) ?
                                 $clog2(TIMEOUT_CYCLES + 1) : 24;
  localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);
  localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StReqStart,
    StReq,
    StData,
    StAck,
    StLineIdle
  } stateT;

  stateT stateQ, stateD;

  logic [SYNC_STAGES-1:0] clkSyncQ, datSyncQ;
  logic                   clkPrevQ;
  logic                   clkSync, datSync, fallEdge;

  logic [7:0]      byteQ, byteD;
  logic [InhW-1:0] inhCntQ, inhCntD;
  logic [ToW-1:0]  toCntQ, toCntD, toCntInc;
  logic [3:0]      bitCntQ, bitCntD, bitNext;
  logic [15:0]     frame;
  logic            timedState;

  logic clkOeQ, clkOeD;
  logic datOeQ, datOeD;
  logic busyQ, busyD;
  logic doneQ, doneD;
  logic errorQ, errorD;

  assign clkSync  = clkSyncQ[SYNC_STAGES-1];
  assign datSync  = datSyncQ[SYNC_STAGES-1];
  assign fallEdge = clkPrevQ & ~clkSync;

  // Upper bits padded so any 4-bit bit index stays in range.
  assign frame = {5'b0, 1'b1, ~^byteQ, byteQ, 1'b0};

  assign toCntInc   = (toCntQ == '1) ? toCntQ : toCntQ + 1'b1;
  assign bitNext    = (bitCntQ == 4'hF) ? bitCntQ : bitCntQ + 4'd1;
  assign timedState = (stateQ == StReq) || (stateQ == StData) ||
                      (stateQ == StAck) || (stateQ == StLineIdle);

  always_comb begin
    stateD  = stateQ;
    byteD   = byteQ;
    inhCntD = inhCntQ;
    toCntD  = toCntQ;
    bitCntD = bitCntQ;
    clkOeD  = clkOeQ;
    datOeD  = datOeQ;
    busyD   = busyQ;
    doneD   = 1'b0;
    errorD  = 1'b0;

    unique case (stateQ)
      StIdle: begin
        busyD  = 1'b0;
        clkOeD = 1'b0;
        datOeD = 1'b0;
        // busyQ still high here means this is the done/error cycle: ignore a start.
        if (tx_start && !busyQ) begin
          byteD   = tx_byte;
          busyD   = 1'b1;
          clkOeD  = 1'b1;
          inhCntD = '0;
          stateD  = StInhibit;
        end
      end
      StInhibit: begin
        if (inhCntQ == InhLast) begin
          datOeD = 1'b1;
          stateD = StReqStart;
        end else begin
          inhCntD = inhCntQ + 1'b1;
        end
      end
      StReqStart: begin
        clkOeD  = 1'b0;
        toCntD  = '0;
        bitCntD = '0;
        stateD  = StReq;
      end
      StReq, StData: begin
        if (fallEdge) begin
          bitCntD = bitNext;
          datOeD  = ~frame[bitNext];
          stateD  = (bitNext == 4'd10) ? StAck : StData;
        end
      end
      StAck: begin
        if (fallEdge) begin
          if (datSync) begin
            errorD = 1'b1;
            clkOeD = 1'b0;
            datOeD = 1'b0;
            stateD = StIdle;
          end else begin
            stateD = StLineIdle;
          end
        end
      end
      StLineIdle: begin
        if (clkSync && datSync) begin
          doneD  = 1'b1;
          stateD = StIdle;
        end
      end
      default: begin
        clkOeD = 1'b0;
        datOeD = 1'b0;
        stateD = StIdle;
      end
    endcase

    // Timeout overrides everything else in the same cycle, including a NACK or done.
    if (timedState) begin
      toCntD = toCntInc;
      if (toCntQ == ToLast) begin
        doneD  = 1'b0;
        errorD = 1'b1;
        clkOeD = 1'b0;
        datOeD = 1'b0;
        stateD = StIdle;
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      clkSyncQ <= '1;
      datSyncQ <= '1;
      clkPrevQ <= 1'b1;
      stateQ   <= StIdle;
      byteQ    <= '0;
      inhCntQ  <= '0;
      toCntQ   <= '0;
      bitCntQ  <= '0;
      clkOeQ   <= 1'b0;
      datOeQ   <= 1'b0;
      busyQ    <= 1'b0;
      doneQ    <= 1'b0;
      errorQ   <= 1'b0;
    end else begin
      clkSyncQ <= {clkSyncQ[SYNC_STAGES-2:0], ps2_clk_in};
      datSyncQ <= {datSyncQ[SYNC_STAGES-2:0], ps2_dat_in};
      clkPrevQ <= clkSync;
      stateQ   <= stateD;
      byteQ    <= byteD;
      inhCntQ  <= inhCntD;
      toCntQ   <= toCntD;
      bitCntQ  <= bitCntD;
      clkOeQ   <= clkOeD;
      datOeQ   <= datOeD;
      busyQ    <= busyD;
      doneQ    <= doneD;
      errorQ   <= errorD;
    end
  end

  assign ps2_clk_oe = clkOeQ;
  assign ps2_dat_oe = datOeQ;
  assign tx_busy    = busyQ;
  assign tx_done    = doneQ;
  assign tx_error   = errorQ;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Directed bench for ps2_host_transmitter with an open-drain keyboard model and a frame
// scoreboard; timeout is shortened so the run stays small.
module tb_ps2_host_transmitter;

  localparam int Inhibit = 5000;
  localparam int Timeout = 4000;
  localparam int Half    = 20;

  logic       Clock    = 1'b0;
  logic       Resetn   = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_byte  = 8'h00;
  logic       devClk   = 1'b1;
  logic       devDat   = 1'b1;
  logic       ps2ClkLine, ps2DatLine;
  logic       ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done, tx_error;

  int testCnt = 0;
  int failCnt = 0;
  int doneCnt = 0;
  int errCnt  = 0;
  int bothCnt = 0;
  int busyBad = 0;
  logic pulsePrev = 1'b0;
  logic [10:0] expQ[$];

  // Wired-AND open-drain lines with pull-ups.
  assign ps2ClkLine = devClk & ~ps2_clk_oe;
  assign ps2DatLine = devDat & ~ps2_dat_oe;

  always #5 Clock = ~Clock;

  ps2_host_transmitter #(
    .INHIBIT_CYCLES(Inhibit),
    .TIMEOUT_CYCLES(Timeout),
    .SYNC_STAGES   (2)
  ) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .tx_start  (tx_start),
    .tx_byte   (tx_byte),
    .ps2_clk_in(ps2ClkLine),
    .ps2_dat_in(ps2DatLine),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .tx_error  (tx_error)
  );

  always @(negedge Clock) begin
    if (Resetn) begin
      if (tx_done) doneCnt <= doneCnt + 1;
      if (tx_error) errCnt <= errCnt + 1;
      if (tx_done && tx_error) bothCnt <= bothCnt + 1;
      if (((tx_done || tx_error) && !tx_busy) || (pulsePrev && tx_busy)) busyBad <= busyBad + 1;
      pulsePrev <= tx_done || tx_error;
    end else begin
      pulsePrev <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    testCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  function automatic logic [10:0] makeFrame(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b, 1'b0};
  endfunction

  task automatic startXfer(input logic [7:0] b, input bit push, input int injectAt,
                           input logic [7:0] injByte);
    int n;
    int both;
    tx_byte  = b;
    tx_start = 1'b1;
    @(negedge Clock);
    tx_start = 1'b0;
    if (push) expQ.push_back(makeFrame(b));
    check("busy_after_start", tx_busy, 1);
    n = 0;
    while (ps2_clk_oe && !ps2_dat_oe && n < 3 * Inhibit) begin
      tx_start = (n == injectAt);
      if (n == injectAt) tx_byte = injByte;
      n++;
      @(negedge Clock);
    end
    tx_start = 1'b0;
    check("inhibit_cycles", n, Inhibit);
    both = 0;
    while (ps2_clk_oe && ps2_dat_oe && both < 10) begin
      both++;
      @(negedge Clock);
    end
    check("req_both_low_cycles", both, 1);
    check("req_lines", {ps2_clk_oe, ps2_dat_oe}, 2'b01);
  endtask

  task automatic devFrame(input bit ackOk, input int abortAt);
    logic [10:0] got;
    logic [10:0] exp;
    bit hold;
    hold = 1'b1;
    got  = '0;
    repeat (5) @(negedge Clock);
    got[0] = ps2DatLine;
    for (int k = 1; k <= 10; k++) begin
      devClk = 1'b0;
      if (k == abortAt) begin
        repeat (Half / 2) @(negedge Clock);
        check("abort_busy_before", tx_busy, 1);
        #2 Resetn = 1'b0;
        #1;
        check("reset_lines_released", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
        check("reset_busy_cleared", tx_busy, 0);
        if (expQ.size() > 0) void'(expQ.pop_front());
        return;
      end
      repeat (Half) @(negedge Clock);
      devClk = 1'b1;
      got[k] = ps2DatLine;
      repeat (Half) @(negedge Clock);
      if (ps2DatLine !== got[k]) hold = 1'b0;
    end
    check("scoreboard_has_entry", expQ.size() > 0, 1);
    exp = (expQ.size() > 0) ? expQ.pop_front() : 11'h7FF;
    check("frame_bits", got, exp);
    check("data_stable_while_clk_high", hold, 1);
    repeat (Half / 2) @(negedge Clock);
    if (ackOk) devDat = 1'b0;
    repeat (Half / 2) @(negedge Clock);
    devClk = 1'b0;
    repeat (Half) @(negedge Clock);
    devClk = 1'b1;
    repeat (Half / 2) @(negedge Clock);
    devDat = 1'b1;
    repeat (10) @(negedge Clock);
  endtask

  task automatic expectEnd(input string tag, input int d0, input int e0, input int dExp,
                           input int eExp);
    check({tag, "_done_pulses"}, doneCnt - d0, dExp);
    check({tag, "_error_pulses"}, errCnt - e0, eExp);
    check({tag, "_idle_busy"}, tx_busy, 0);
    check({tag, "_idle_lines"}, {ps2_clk_oe, ps2_dat_oe}, 2'b00);
  endtask

  initial begin
    int d0;
    int e0;
    int n;

    repeat (3) @(negedge Clock);
    check("reset_outputs", {ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done, tx_error}, 5'b0);
    Resetn = 1'b1;
    repeat (3) @(negedge Clock);
    check("idle_outputs", {ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done, tx_error}, 5'b0);

    // 0xED with ack
    d0 = doneCnt; e0 = errCnt;
    startXfer(8'hED, 1'b1, -1, 8'h00);
    devFrame(1'b1, 0);
    expectEnd("ed", d0, e0, 1, 0);

    // parity 0 then parity 1
    d0 = doneCnt; e0 = errCnt;
    startXfer(8'h07, 1'b1, -1, 8'h00);
    devFrame(1'b1, 0);
    expectEnd("b07", d0, e0, 1, 0);
    d0 = doneCnt; e0 = errCnt;
    startXfer(8'h00, 1'b1, -1, 8'h00);
    devFrame(1'b1, 0);
    expectEnd("b00", d0, e0, 1, 0);

    // keyboard never clocks
    d0 = doneCnt; e0 = errCnt;
    startXfer(8'h3C, 1'b0, -1, 8'h00);
    n = 0;
    while (!tx_error && n < Timeout + 100) begin
      @(negedge Clock);
      n++;
    end
    check("timeout_latency", n, Timeout);
    check("timeout_lines", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    check("timeout_busy_in_pulse", tx_busy, 1);
    @(negedge Clock);
    check("timeout_busy_after", tx_busy, 0);
    repeat (3) @(negedge Clock);
    expectEnd("timeout", d0, e0, 0, 1);

    // NACK
    d0 = doneCnt; e0 = errCnt;
    startXfer(8'hA5, 1'b1, -1, 8'h00);
    devFrame(1'b0, 0);
    expectEnd("nack", d0, e0, 0, 1);

    // reset on data bit 4, then a clean resend
    d0 = doneCnt; e0 = errCnt;
    startXfer(8'h5A, 1'b1, -1, 8'h00);
    devFrame(1'b1, 5);
    devClk = 1'b1;
    devDat = 1'b1;
    repeat (3) @(negedge Clock);
    Resetn = 1'b1;
    repeat (5) @(negedge Clock);
    expectEnd("reset_abort", d0, e0, 0, 0);
    d0 = doneCnt; e0 = errCnt;
    startXfer(8'h5A, 1'b1, -1, 8'h00);
    devFrame(1'b1, 0);
    expectEnd("b5a_resend", d0, e0, 1, 0);

    // start request while busy must be dropped
    d0 = doneCnt; e0 = errCnt;
    startXfer(8'hED, 1'b1, 100, 8'h12);
    devFrame(1'b1, 0);
    expectEnd("collision", d0, e0, 1, 0);
    n = 0;
    for (int i = 0; i < Inhibit + 200; i++) begin
      @(negedge Clock);
      if (ps2_clk_oe || tx_busy) n++;
    end
    check("ignored_start_not_sent", n, 0);
    check("scoreboard_empty", expQ.size(), 0);
    check("done_error_overlap", bothCnt, 0);
    check("busy_pulse_framing", busyBad, 0);

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
